// File: rtl/demux_1x2_8_reg.sv
// Registered 1-to-2 demultiplexer with per-channel valid/ack handshake.
// Define DEMUX_OVERWRITE_EN to let a load overwrite a full channel and set the sticky OVR flag.
module demux_1x2_8_reg #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic [WIDTH-1:0] D,
    input  logic             SEL,
    input  logic             LOAD,
    output logic             READY,
    output logic [WIDTH-1:0] A,
    output logic [WIDTH-1:0] B,
    output logic             A_VALID,
    output logic             B_VALID,
    input  logic             A_ACK,
    input  logic             B_ACK,
    output logic             OVR
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } chan_state_t;

    chan_state_t      a_state;
    chan_state_t      b_state;
    logic [WIDTH-1:0] a_data;
    logic [WIDTH-1:0] b_data;
    logic             accept;
    logic             a_load;
    logic             b_load;

`ifdef DEMUX_OVERWRITE_EN
    logic ovr;

    assign READY = 1'b1;
    assign OVR   = ovr;
`else
    // READY never looks at LOAD, so the producer may derive LOAD from READY.
    assign READY = SEL ? ((b_state == EMPTY) || B_ACK)
                       : ((a_state == EMPTY) || A_ACK);
    assign OVR   = 1'b0;
`endif

    always_comb begin
        accept = LOAD && READY;
        a_load = accept && !SEL;
        b_load = accept && SEL;
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            a_state <= EMPTY;
            b_state <= EMPTY;
            a_data  <= '0;
            b_data  <= '0;
`ifdef DEMUX_OVERWRITE_EN
            ovr     <= 1'b0;
`endif
        end else begin
            // A load wins over an ack in the same cycle, so the channel stays full with new data.
            if (a_load) begin
                a_data  <= D;
                a_state <= FULL;
            end else if (A_ACK) begin
                a_state <= EMPTY;
            end

            if (b_load) begin
                b_data  <= D;
                b_state <= FULL;
            end else if (B_ACK) begin
                b_state <= EMPTY;
            end

`ifdef DEMUX_OVERWRITE_EN
            if ((a_load && (a_state == FULL) && !A_ACK) ||
                (b_load && (b_state == FULL) && !B_ACK)) begin
                ovr <= 1'b1;
            end
`endif
        end
    end

    assign A       = a_data;
    assign B       = b_data;
    assign A_VALID = (a_state == FULL);
    assign B_VALID = (b_state == FULL);

endmodule

// File: tb/tb_demux_1x2_8_reg.sv
// Bench for demux_1x2_8_reg: directed scenarios then random traffic against a
// channel-array reference model; follows DEMUX_OVERWRITE_EN if defined.
module tb_demux_1x2_8_reg;

    logic       CLK = 1'b0;
    logic       RST_N;
    logic [7:0] D;
    logic       SEL;
    logic       LOAD;
    logic       READY;
    logic [7:0] A;
    logic [7:0] B;
    logic       A_VALID;
    logic       B_VALID;
    logic       A_ACK;
    logic       B_ACK;
    logic       OVR;

    int errors = 0;
    int checks = 0;

`ifdef DEMUX_OVERWRITE_EN
    localparam bit OVW = 1'b1;
`else
    localparam bit OVW = 1'b0;
`endif

    // Reference model: index 0 is channel A, index 1 is channel B.
    logic [7:0] m_data  [2];
    logic       m_valid [2];
    logic       m_ovr;

    always #5 CLK = ~CLK;

    demux_1x2_8_reg #(.WIDTH(8)) dut (
        .CLK     (CLK),
        .RST_N   (RST_N),
        .D       (D),
        .SEL     (SEL),
        .LOAD    (LOAD),
        .READY   (READY),
        .A       (A),
        .B       (B),
        .A_VALID (A_VALID),
        .B_VALID (B_VALID),
        .A_ACK   (A_ACK),
        .B_ACK   (B_ACK),
        .OVR     (OVR)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic rstn, input logic sel, input logic load,
                        input logic aack, input logic back, input logic [7:0] d,
                        input bit chk_rdy);
        logic       ack [2];
        logic       exp_rdy;
        int         ch;
        RST_N = rstn;
        SEL   = sel;
        LOAD  = load;
        A_ACK = aack;
        B_ACK = back;
        D     = d;
        ack[0] = aack;
        ack[1] = back;
        ch = sel ? 1 : 0;
        #1;
        exp_rdy = OVW ? 1'b1 : (!m_valid[ch] || ack[ch]);
        if (chk_rdy) check("ready", {31'b0, READY}, {31'b0, exp_rdy});
        @(posedge CLK);
        #1;
        if (!rstn) begin
            m_data[0]  = '0;
            m_data[1]  = '0;
            m_valid[0] = 1'b0;
            m_valid[1] = 1'b0;
            m_ovr      = 1'b0;
        end else begin
            for (int c = 0; c < 2; c++) begin
                if (load && exp_rdy && (ch == c)) begin
                    if (OVW && m_valid[c] && !ack[c]) m_ovr = 1'b1;
                    m_data[c]  = d;
                    m_valid[c] = 1'b1;
                end else if (ack[c]) begin
                    m_valid[c] = 1'b0;
                end
            end
        end
        check("a_data",  {24'b0, A},       {24'b0, m_data[0]});
        check("b_data",  {24'b0, B},       {24'b0, m_data[1]});
        check("a_valid", {31'b0, A_VALID}, {31'b0, m_valid[0]});
        check("b_valid", {31'b0, B_VALID}, {31'b0, m_valid[1]});
        check("ovr",     {31'b0, OVR},     {31'b0, m_ovr});
    endtask

    initial begin
        m_data[0]  = '0;
        m_data[1]  = '0;
        m_valid[0] = 1'b0;
        m_valid[1] = 1'b0;
        m_ovr      = 1'b0;

        // Reset; READY is unknown until the first reset edge.
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h33, 1'b1);

        // Load A.
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h48, 1'b1);
        check("dir_a_48", {24'b0, A}, 32'h48);
        check("dir_b_0",  {24'b0, B}, 32'h00);

        // Load B, then acknowledge A; A data must persist.
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h55, 1'b1);
        check("dir_b_55", {24'b0, B}, 32'h55);
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1);
        check("dir_a_hold",  {24'b0, A}, 32'h48);
        check("dir_a_empty", {31'b0, A_VALID}, 32'h0);

        // Load into full B without ack.
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'hAA, 1'b1);
        check("dir_b_full_load", {24'b0, B}, OVW ? 32'hAA : 32'h55);
        check("dir_ovr",         {31'b0, OVR}, OVW ? 32'h1 : 32'h0);

        // Ack and load B in the same cycle.
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 8'h0F, 1'b1);
        check("dir_b_0f",    {24'b0, B}, 32'h0F);
        check("dir_b_valid", {31'b0, B_VALID}, 32'h1);

        // Fill A, then reset against a concurrent load.
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h11, 1'b1);
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'hFF, 1'b1);
        check("dir_rst_a",   {24'b0, A}, 32'h0);
        check("dir_rst_ovr", {31'b0, OVR}, 32'h0);

        // Ack on an empty channel is ignored.
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'h77, 1'b1);

        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 39) != 0), 1'($urandom), 1'($urandom),
                 ($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0),
                 8'($urandom), 1'b1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
